// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage
// Instruction fetch stage and IF/ID pipeline register for the pipelined OTTER core.
// Owns the PC, keeps at most one request outstanding to a variable-latency
// instruction memory, and presents {IR, PC, valid} to decode. A one-entry skid
// buffer absorbs a response that arrives while decode is stalled, and a
// redirect flushes everything fetched down the old path.

module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_VALID
);

  // REQ : request on the bus for pc_q
  // WAIT: one request accepted, response pending
  // HELD: response parked in the skid buffer until decode can take it
  // DROP: the pending response belongs to a flushed path and is discarded
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        vld_q, vld_d;

  logic        accept;
  logic        load_mem;
  logic        load_skid;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  // IF/ID can take a new entry when it is empty or decode is consuming it.
  assign accept       = !vld_q || !STALL;
  assign redirect_tgt = {REDIRECT_PC[31:2], 2'b00};

  // The two low target bits are architecturally ignored.
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  // Request is a pure function of state, forced low while reset is asserted.
  assign IMEM_REQ    = (state_q == ST_REQ) && !RST;
  assign IMEM_ADDR   = pc_q;
  assign IF_ID_IR    = ir_q;
  assign IF_ID_PC    = ifpc_q;
  assign IF_ID_VALID = vld_q;

  // Next-state logic: fetch FSM, PC, skid buffer and IF/ID register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    skid_ir_d  = skid_ir_q;
    skid_pc_d  = skid_pc_q;
    load_mem   = 1'b0;
    load_skid  = 1'b0;

    case (state_q)
      ST_REQ: begin
        // Any response seen here is stale; only a grant matters.
        if (IMEM_GNT) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (IMEM_RVALID) begin
          if (accept) begin
            load_mem = 1'b1;
            state_d  = ST_REQ;
          end else begin
            skid_ir_d = IMEM_RDATA;
            skid_pc_d = fetch_pc_q;
            state_d   = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        // Being in HELD is what marks the skid buffer as full.
        if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_DROP: begin
        if (IMEM_RVALID) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    vld_d  = vld_q;
    ir_d   = ir_q;
    ifpc_d = ifpc_q;
    if (load_mem) begin
      vld_d  = 1'b1;
      ir_d   = IMEM_RDATA;
      ifpc_d = fetch_pc_q;
    end else if (load_skid) begin
      vld_d  = 1'b1;
      ir_d   = skid_ir_q;
      ifpc_d = skid_pc_q;
    end else if (!STALL) begin
      // Decode consumed the entry and nothing replaces it: insert a bubble.
      vld_d = 1'b0;
      ir_d  = NOP_INSTR;
    end

    // A redirect overrides stall and any load in the same cycle. Leaving
    // HELD empties the skid buffer; a response still owed to the old path
    // is swallowed in DROP.
    if (REDIRECT) begin
      vld_d = 1'b0;
      ir_d  = NOP_INSTR;
      pc_d  = redirect_tgt;
      case (state_q)
        ST_REQ:  state_d = IMEM_GNT    ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = IMEM_RVALID ? ST_REQ  : ST_DROP;
        ST_HELD: state_d = ST_REQ;
        ST_DROP: state_d = IMEM_RVALID ? ST_REQ  : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Control state and IF/ID register, with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      ir_q    <= NOP_INSTR;
      ifpc_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      ir_q    <= ir_d;
      ifpc_q  <= ifpc_d;
    end
  end

  // Fetch address and skid payload; only read when the FSM says they are live.
  always_ff @(posedge CLK) begin
    fetch_pc_q <= fetch_pc_d;
    skid_ir_q  <= skid_ir_d;
    skid_pc_q  <= skid_pc_d;
  end

endmodule
